// File: rtl/pipeline_ctrl.sv
// Pipeline control unit: per-stage stall/flush strobes for an N-stage in-order
// pipeline, redirect arbitration, post-reset flush window, perf counters and a
// fetch-stall watchdog.
//
// Ports:
//   clk, rst_n         core clock (rising edge), async active-low reset
//   stall_req_i        bit j: stage j cannot advance this cycle
//   redir_valid_i      bit r: redirect source r is requesting this cycle
//   redir_stage_i      packed SW-bit stage index per source
//   redir_target_i     packed 32-bit target PC per source
//   stall_o            bit i: stage i holds its input register
//   flush_o            bit i: stage i input register loads a bubble (bit 0 always 0)
//   pc_redirect_o      fetch loads pc_target_o
//   pc_target_o        winning redirect target
//   in_reset_flush_o   post-reset flush window active
//   stall_cycles_o     saturating count of cycles with stall_o[0]
//   redirect_count_o   saturating count of cycles with pc_redirect_o
//   wdog_trip_o        sticky watchdog flag
module pipeline_ctrl #(
  parameter int unsigned NUM_STAGES       = 5,
  parameter int unsigned NUM_REDIR        = 2,
  parameter int unsigned RST_FLUSH_CYCLES = 2,
  parameter int unsigned WDOG_LIMIT       = 1024,
  parameter int unsigned CNT_W            = 32,
  localparam int unsigned SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_STAGES-1:0]   stall_req_i,
  input  logic [NUM_REDIR-1:0]    redir_valid_i,
  input  logic [NUM_REDIR*SW-1:0] redir_stage_i,
  input  logic [NUM_REDIR*32-1:0] redir_target_i,
  output logic [NUM_STAGES-1:0]   stall_o,
  output logic [NUM_STAGES-1:0]   flush_o,
  output logic                    pc_redirect_o,
  output logic [31:0]             pc_target_o,
  output logic                    in_reset_flush_o,
  output logic [CNT_W-1:0]        stall_cycles_o,
  output logic [CNT_W-1:0]        redirect_count_o,
  output logic                    wdog_trip_o
);

  localparam int unsigned RCW = $clog2(RST_FLUSH_CYCLES + 1);
  localparam int unsigned WCW = $clog2(WDOG_LIMIT + 1);

  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic [WCW-1:0]   wdog_cnt_q, wdog_cnt_d;
  logic             trip_q, trip_d;

  logic                  in_win;
  logic                  redir_any;
  logic [SW-1:0]         win_stage;
  logic [31:0]           win_target;
  logic [31:0]           win_k;
  logic [NUM_STAGES-1:0] bp;

  // Window is live whenever the down-counter is nonzero; reset loads it, so the
  // window outputs appear asynchronously with rst_n.
  assign in_win = (rst_cnt_q != '0);

  // Oldest instruction (highest stage) wins; strict '>' keeps the lower index on ties.
  always_comb begin
    redir_any  = 1'b0;
    win_stage  = '0;
    win_target = '0;
    for (int unsigned r = 0; r < NUM_REDIR; r++) begin
      if (redir_valid_i[r] && (!redir_any || (redir_stage_i[r*SW +: SW] > win_stage))) begin
        redir_any  = 1'b1;
        win_stage  = redir_stage_i[r*SW +: SW];
        win_target = redir_target_i[r*32 +: 32];
      end
    end
  end

  assign win_k = 32'(win_stage);

  // A stalled stage blocks every younger (lower-index) stage behind it.
  always_comb begin
    bp = '0;
    bp[NUM_STAGES-1] = stall_req_i[NUM_STAGES-1];
    for (int i = int'(NUM_STAGES) - 2; i >= 0; i--) begin
      bp[i] = stall_req_i[i] | bp[i+1];
    end
  end

  always_comb begin
    stall_o       = '0;
    flush_o       = '0;
    pc_redirect_o = 1'b0;
    pc_target_o   = '0;
    if (in_win) begin
      stall_o[0] = 1'b1;
      flush_o    = '1;
      flush_o[0] = 1'b0;
    end else begin
      pc_redirect_o = redir_any;
      pc_target_o   = win_target;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        stall_o[i] = (redir_any && (i <= win_k)) ? 1'b0 : bp[i];
      end
      // Squash stages younger than the redirect, and insert a bubble wherever a
      // stalled stage feeds a moving one.
      for (int unsigned i = 1; i < NUM_STAGES; i++) begin
        flush_o[i] = (redir_any && (i <= win_k)) | (stall_o[i-1] & ~stall_o[i]);
      end
    end
  end

  always_comb begin
    rst_cnt_d   = rst_cnt_q;
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    wdog_cnt_d  = wdog_cnt_q;
    if (in_win) begin
      rst_cnt_d  = rst_cnt_q - RCW'(1);
      wdog_cnt_d = '0;
    end else begin
      if (stall_o[0] && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (pc_redirect_o && (redir_cnt_q != {CNT_W{1'b1}})) begin
        redir_cnt_d = redir_cnt_q + CNT_W'(1);
      end
      if (!stall_o[0]) begin
        wdog_cnt_d = '0;
      end else if (wdog_cnt_q != WCW'(WDOG_LIMIT)) begin
        wdog_cnt_d = wdog_cnt_q + WCW'(1);
      end
    end
    trip_d = trip_q | (wdog_cnt_d == WCW'(WDOG_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q   <= RCW'(RST_FLUSH_CYCLES);
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
      wdog_cnt_q  <= '0;
      trip_q      <= 1'b0;
    end else begin
      rst_cnt_q   <= rst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
      wdog_cnt_q  <= wdog_cnt_d;
      trip_q      <= trip_d;
    end
  end

  assign in_reset_flush_o = in_win;
  assign stall_cycles_o   = stall_cnt_q;
  assign redirect_count_o = redir_cnt_q;
  assign wdog_trip_o      = trip_q;

endmodule
